// File: rtl/vector_checker.sv
// Vector checker: replays a loaded {op, expected snapshot} table into a core and
// compares the core's register snapshot LAT cycles later. Define VECCHK_MASK_EN for per-channel masks.
module vector_checker #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 7,
  parameter int OP_W   = 8,
  parameter int DEPTH  = 64,
  parameter int LAT    = 1,
  parameter int CNT_W  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ld_we,
  input  logic [AW-1:0]            ld_addr,
  input  logic                     ld_valid,
  input  logic [OP_W-1:0]          ld_op,
  input  logic [NUM_CH*DATA_W-1:0] ld_exp,
`ifdef VECCHK_MASK_EN
  input  logic [NUM_CH-1:0]        ld_mask,
`endif
  input  logic [NUM_CH*DATA_W-1:0] obs,
  output logic [OP_W-1:0]          op_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         vec_count,
  output logic [CNT_W-1:0]         err_count,
  output logic                     err_pulse,
  output logic [AW-1:0]            first_err_idx,
  output logic [NUM_CH-1:0]        first_err_ch
);

  localparam int SW  = NUM_CH * DATA_W;
  localparam int IW  = AW + 1;
  localparam int DCW = $clog2(LAT + 1);
`ifdef VECCHK_MASK_EN
  localparam int EW  = 1 + OP_W + SW + NUM_CH;
`else
  localparam int EW  = 1 + OP_W + SW;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [DCW-1:0]  drain_reg;

  logic [EW-1:0]   tbl [DEPTH];
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   ent;
  logic [AW-1:0]   rd_addr;
  logic            ent_valid;
  logic [OP_W-1:0] ent_op;
  logic [SW-1:0]   ent_exp;
  logic [NUM_CH-1:0] ent_mask;

  logic            issue_end;
  logic            push_valid;

  logic              pipe_valid [LAT];
  logic [AW-1:0]     pipe_idx   [LAT];
  logic [SW-1:0]     pipe_exp   [LAT];
  logic [NUM_CH-1:0] pipe_mask  [LAT];

  logic              cmp_valid;
  logic              cmp_fail;
  logic [NUM_CH-1:0] fail_ch;
  logic [CNT_W-1:0]  err_upd;

`ifdef VECCHK_MASK_EN
  assign wr_entry = {ld_valid, ld_op, ld_exp, ld_mask};
  assign ent_mask = ent[NUM_CH-1:0];
`else
  assign wr_entry = {ld_valid, ld_op, ld_exp};
  assign ent_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (ld_we && !busy) tbl[ld_addr] <= wr_entry;
  end

  // A write on the start edge must be seen by the op issued on that edge.
  always_comb begin
    rd_addr = (state_reg == RUN) ? idx_reg[AW-1:0] : '0;
    ent     = (ld_we && !busy && (ld_addr == rd_addr)) ? wr_entry : tbl[rd_addr];
  end

  assign ent_valid  = ent[EW-1];
  assign ent_op     = ent[EW-2 -: OP_W];
  assign ent_exp    = ent[EW-2-OP_W -: SW];
  assign issue_end  = (idx_reg == IW'(DEPTH)) || !ent_valid;
  assign push_valid = (start && (state_reg == IDLE || state_reg == DONE) && ent_valid) ||
                      (state_reg == RUN && !issue_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_valid[i] <= 1'b0;
    end else begin
      pipe_valid[0] <= push_valid;
      pipe_idx[0]   <= rd_addr;
      pipe_exp[0]   <= ent_exp;
      pipe_mask[0]  <= ent_mask;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
        pipe_exp[i]   <= pipe_exp[i-1];
        pipe_mask[i]  <= pipe_mask[i-1];
      end
    end
  end

  assign cmp_valid = pipe_valid[LAT-1];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign fail_ch[gi] = (obs[gi*DATA_W +: DATA_W] != pipe_exp[LAT-1][gi*DATA_W +: DATA_W]) &&
                           !pipe_mask[LAT-1][gi];
    end
  endgenerate

  assign cmp_fail = cmp_valid && (fail_ch != '0);
  assign err_upd  = (cmp_fail && (err_count != '1)) ? err_count + CNT_W'(1) : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      drain_reg     <= '0;
      op_out        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      err_pulse     <= 1'b0;
      first_err_idx <= '0;
      first_err_ch  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (cmp_valid) begin
        vec_count <= vec_count + CNT_W'(1);
        err_count <= err_upd;
        err_pulse <= cmp_fail;
        if (cmp_fail && (err_count == '0)) begin
          first_err_idx <= pipe_idx[LAT-1];
          first_err_ch  <= fail_ch;
        end
      end
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            done          <= 1'b0;
            pass          <= 1'b0;
            vec_count     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_ch  <= '0;
            busy          <= 1'b1;
            if (ent_valid) begin
              op_out    <= ent_op;
              idx_reg   <= IW'(1);
              state_reg <= RUN;
            end else begin
              // Empty table: nothing issued, just wait out the pipe latency.
              op_out    <= '0;
              drain_reg <= DCW'(LAT);
              state_reg <= DRAIN;
            end
          end
        end
        RUN: begin
          if (issue_end) begin
            op_out <= '0;
            if (LAT == 1) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_upd == '0);
            end else begin
              drain_reg <= DCW'(LAT - 1);
              state_reg <= DRAIN;
            end
          end else begin
            op_out  <= ent_op;
            idx_reg <= idx_reg + IW'(1);
          end
        end
        DRAIN: begin
          if (drain_reg == DCW'(1)) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_upd == '0);
          end else begin
            drain_reg <= drain_reg - DCW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// Bench for vector_checker: two instances (LAT=1/CNT_W=3 and LAT=3/CNT_W=2) share
// the table-load and control stimulus; each sees a fake core that echoes its ops.
module tb_vector_checker;

  localparam int DW = 8, NCH = 7, OW = 8, DEP = 4, AW = 2, SW = NCH * DW;
  localparam int LAT_A = 1, CW_A = 3, LAT_B = 3, CW_B = 2;
  localparam int LATS [2] = '{LAT_A, LAT_B};
  localparam int CWS  [2] = '{CW_A, CW_B};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, ld_we = 1'b0, ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [OW-1:0] ld_op = '0;
  logic [SW-1:0] ld_exp = '0;
  logic [NCH-1:0] ld_mask = '0;

  logic [SW-1:0] obs_a, obs_b;
  logic [OW-1:0] dly_b [2];

  logic [OW-1:0] op_a, op_b;
  logic busy_a, busy_b, done_a, done_b, pass_a, pass_b, pulse_a, pulse_b;
  logic [CW_A-1:0] vec_a, err_a;
  logic [CW_B-1:0] vec_b, err_b;
  logic [AW-1:0] fidx_a, fidx_b;
  logic [NCH-1:0] fch_a, fch_b;

  vector_checker #(.DATA_W(DW), .NUM_CH(NCH), .OP_W(OW), .DEPTH(DEP), .LAT(LAT_A), .CNT_W(CW_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_valid(ld_valid),
    .ld_op(ld_op), .ld_exp(ld_exp),
`ifdef VECCHK_MASK_EN
    .ld_mask(ld_mask),
`endif
    .obs(obs_a), .op_out(op_a), .busy(busy_a), .done(done_a), .pass(pass_a), .vec_count(vec_a),
    .err_count(err_a), .err_pulse(pulse_a), .first_err_idx(fidx_a), .first_err_ch(fch_a));

  vector_checker #(.DATA_W(DW), .NUM_CH(NCH), .OP_W(OW), .DEPTH(DEP), .LAT(LAT_B), .CNT_W(CW_B)) u_b (
    .clk(clk), .rst(rst), .start(start), .ld_we(ld_we), .ld_addr(ld_addr), .ld_valid(ld_valid),
    .ld_op(ld_op), .ld_exp(ld_exp),
`ifdef VECCHK_MASK_EN
    .ld_mask(ld_mask),
`endif
    .obs(obs_b), .op_out(op_b), .busy(busy_b), .done(done_b), .pass(pass_b), .vec_count(vec_b),
    .err_count(err_b), .err_pulse(pulse_b), .first_err_idx(fidx_b), .first_err_ch(fch_b));

  // Fake core: channel c holds op ^ (c*0x10); snapshot appears LAT cycles after the op.
  function automatic logic [SW-1:0] core_fn(input logic [OW-1:0] op);
    logic [SW-1:0] r;
    for (int c = 0; c < NCH; c++) r[c*DW +: DW] = op ^ 8'(c * 16);
    return r;
  endfunction

  assign obs_a = core_fn(op_a);
  assign obs_b = core_fn(dly_b[1]);
  always @(posedge clk) begin
    dly_b[0] <= op_b;
    dly_b[1] <= dly_b[0];
  end

  int n_checks = 0, n_errors = 0;
  bit chk_en = 1'b0;
  int pc_a = 0, pc_b = 0;

  task automatic chk(input string nm, input int u, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s u=%0d @%0t got=%0h want=%0h", nm, u, $time, got, want);
    end
  endtask

  // Model: table per instance, plus a snapshot of the run taken at start.
  bit             m_valid [2][DEP];
  logic [OW-1:0]  m_op    [2][DEP];
  logic [SW-1:0]  m_exp   [2][DEP];
  logic [NCH-1:0] m_mask  [2][DEP];
  bit             m_act [2];
  int             m_t [2];
  int             m_n [2];
  logic [OW-1:0]  r_op   [2][DEP];
  logic [NCH-1:0] r_fail [2][DEP];

  function automatic int done_cyc(input int u);
    return (m_n[u] > 0) ? m_n[u] + LATS[u] : LATS[u] + 1;
  endfunction

  function automatic bit m_busy(input int u);
    return m_act[u] && (m_t[u] < done_cyc(u));
  endfunction

  initial begin : model_proc
    bit b;
    logic [SW-1:0] snap;
    logic [NCH-1:0] f;
    for (int u = 0; u < 2; u++) begin m_act[u] = 0; m_t[u] = 0; m_n[u] = 0; end
    forever begin
      @(posedge clk);
      for (int u = 0; u < 2; u++) begin
        if (rst) begin
          m_act[u] = 0;
          m_t[u] = 0;
        end else begin
          b = m_busy(u);
          if (ld_we && !b) begin
            m_valid[u][ld_addr] = ld_valid;
            m_op[u][ld_addr]    = ld_op;
            m_exp[u][ld_addr]   = ld_exp;
            m_mask[u][ld_addr]  = ld_mask;
          end
          if (start && !b) begin
            m_n[u] = DEP;
            for (int k = DEP - 1; k >= 0; k--) if (!m_valid[u][k]) m_n[u] = k;
            for (int k = 0; k < DEP; k++) begin
              snap = core_fn(m_op[u][k]);
              for (int c = 0; c < NCH; c++) f[c] = snap[c*DW +: DW] != m_exp[u][k][c*DW +: DW];
`ifdef VECCHK_MASK_EN
              f = f & ~m_mask[u][k];
`endif
              r_op[u][k] = m_op[u][k];
              r_fail[u][k] = f;
            end
            m_act[u] = 1;
            m_t[u] = 1;
          end else if (m_act[u]) begin
            m_t[u]++;
          end
        end
      end
    end
  end

  initial begin : cmp_proc
    int lat, n, t, dc, ncmp, errs, fk, pk;
    longint vmax, e_op, e_busy, e_done, e_pass, e_vec, e_err, e_pulse, e_fidx, e_fch;
    forever begin
      @(negedge clk);
      if (pulse_a) pc_a++;
      if (pulse_b) pc_b++;
      if (chk_en) begin
        for (int u = 0; u < 2; u++) begin
          lat = LATS[u]; n = m_n[u]; t = m_t[u];
          vmax = (longint'(1) << CWS[u]) - 1;
          e_op = 0; e_busy = 0; e_done = 0; e_pass = 0; e_vec = 0;
          e_err = 0; e_pulse = 0; e_fidx = 0; e_fch = 0;
          if (m_act[u]) begin
            dc = done_cyc(u);
            e_op   = (t <= n) ? longint'(r_op[u][t-1]) : 0;
            e_busy = (t < dc) ? 1 : 0;
            e_done = (t >= dc) ? 1 : 0;
            ncmp = t - lat;
            if (ncmp < 0) ncmp = 0;
            if (ncmp > n) ncmp = n;
            errs = 0; fk = -1;
            for (int k = 0; k < ncmp; k++) begin
              if (r_fail[u][k] != '0) begin
                errs++;
                if (fk < 0) fk = k;
              end
            end
            e_vec  = ncmp & vmax;
            e_err  = (errs > vmax) ? vmax : errs;
            e_pass = (e_done == 1 && errs == 0) ? 1 : 0;
            pk = t - lat - 1;
            e_pulse = (pk >= 0 && pk < n && r_fail[u][pk] != '0) ? 1 : 0;
            if (fk >= 0) begin
              e_fidx = fk;
              e_fch  = r_fail[u][fk];
            end
          end
          chk("op_out",  u, (u == 0) ? op_a   : op_b,   e_op);
          chk("busy",    u, (u == 0) ? busy_a : busy_b, e_busy);
          chk("done",    u, (u == 0) ? done_a : done_b, e_done);
          chk("pass",    u, (u == 0) ? pass_a : pass_b, e_pass);
          chk("vec",     u, (u == 0) ? longint'(vec_a) : longint'(vec_b), e_vec);
          chk("err",     u, (u == 0) ? longint'(err_a) : longint'(err_b), e_err);
          chk("pulse",   u, (u == 0) ? pulse_a : pulse_b, e_pulse);
          chk("fidx",    u, (u == 0) ? fidx_a : fidx_b, e_fidx);
          chk("fch",     u, (u == 0) ? fch_a  : fch_b,  e_fch);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input bit v, input logic [OW-1:0] op,
                    input logic [SW-1:0] x, input logic [NCH-1:0] m);
    ld_we = 1; ld_addr = a; ld_valid = v; ld_op = op; ld_exp = x; ld_mask = m;
    tick();
    ld_we = 0;
  endtask

  task automatic go();
    pc_a = 0; pc_b = 0;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic go_wr(input logic [AW-1:0] a, input logic [OW-1:0] op);
    pc_a = 0; pc_b = 0;
    ld_we = 1; ld_addr = a; ld_valid = 1; ld_op = op; ld_exp = core_fn(op); ld_mask = '0;
    start = 1;
    tick();
    start = 0; ld_we = 0;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (!(done_a && done_b) && c < 40) begin
      tick();
      c++;
    end
    chk(nm, -1, done_a && done_b, 1);
  endtask

  initial begin : stim
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst_op", -1, op_a, 0);
    chk("rst_busy", -1, busy_b, 0);
    chk("rst_done", -1, done_a, 0);

    // T1: three valid entries, obs tracks exp
    wr(0, 1, 8'h11, core_fn(8'h11), '0);
    wr(1, 1, 8'h22, core_fn(8'h22), '0);
    wr(2, 1, 8'h33, core_fn(8'h33), '0);
    wr(3, 0, 8'h44, core_fn(8'h44), '0);
    go();
    chk("t1_op0", 0, op_a, 8'h11);
    tick();
    chk("t1_op1", 0, op_a, 8'h22);
    tick();
    chk("t1_op2", 0, op_a, 8'h33);
    chk("t1_notdone", 0, done_a, 0);
    tick();
    chk("t1_op3", 0, op_a, 8'h00);
    chk("t1_done", 0, done_a, 1);
    chk("t1_vec", 0, vec_a, 3);
    chk("t1_pass", 0, pass_a, 1);
    wait_done("t1_timeout");
    chk("t1_vec_b", 1, vec_b, 3);
    chk("t1_pass_b", 1, pass_b, 1);

    // T2: entry1 channel A expected 0x05, core gives 0x04
    wr(1, 1, 8'h64, core_fn(8'h64) ^ (56'h01 << 48), '0);
    go();
    wait_done("t2_timeout");
    tick();
    chk("t2_err", 0, err_a, 1);
    chk("t2_fidx", 0, fidx_a, 1);
    chk("t2_fch", 0, fch_a, 7'b1000000);
    chk("t2_pass", 0, pass_a, 0);
    chk("t2_pulses_a", 0, pc_a, 1);
    chk("t2_pulses_b", 1, pc_b, 1);

    // T3/T4: full table, every entry failing; B saturates its 2-bit error count
    wr(0, 1, 8'h10, core_fn(8'h10) ^ 56'h01, '0);
    wr(1, 1, 8'h20, core_fn(8'h20) ^ (56'h80 << 16), '0);
    wr(2, 1, 8'h30, core_fn(8'h30) ^ (56'h02 << 48), '0);
    wr(3, 1, 8'h40, core_fn(8'h40) ^ (56'h04 << 32), '0);
    go();
    wait_done("t3_timeout");
    tick();
    chk("t3_err_sat", 1, err_b, 3);
    chk("t3_pulses_b", 1, pc_b, 4);
    chk("t3_fidx_b", 1, fidx_b, 0);
    chk("t3_fch_b", 1, fch_b, 7'b0000001);
    chk("t4_vec_a", 0, vec_a, 4);
    chk("t4_err_a", 0, err_a, 4);
    chk("t4_op_idle", 0, op_a, 0);

    // T4: entry 0 invalid
    wr(0, 0, 8'h10, core_fn(8'h10), '0);
    go();
    chk("t4_busy", 0, busy_a, 1);
    wait_done("t4_timeout");
    chk("t4_vec0", 0, vec_a, 0);
    chk("t4_pass", 0, pass_a, 1);
    chk("t4_pass_b", 1, pass_b, 1);

    // T5: reset mid-run, then writes while busy must be dropped
    wr(0, 1, 8'h11, core_fn(8'h11), '0);
    wr(1, 1, 8'h22, core_fn(8'h22), '0);
    wr(2, 1, 8'h33, core_fn(8'h33), '0);
    wr(3, 0, 8'h44, core_fn(8'h44), '0);
    go();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t5_op", 0, op_a, 0);
    chk("t5_busy", 0, busy_a, 0);
    chk("t5_vec", 1, vec_b, 0);
    chk("t5_done", 1, done_b, 0);
    go();
    wr(1, 1, 8'h99, core_fn(8'h99), '0);
    chk("t5_op1", 0, op_a, 8'h22);
    wait_done("t5_timeout");
    chk("t5_vec_rerun", 0, vec_a, 3);

    // Write and start on the same edge: the run uses the new entry 0
    go_wr(0, 8'h5A);
    chk("t7_op0", 0, op_a, 8'h5A);
    wait_done("t7_timeout");
    chk("t7_pass", 0, pass_a, 1);

    // T6: channel L mismatch on a masked channel
    wr(0, 1, 8'h11, core_fn(8'h11) ^ 56'h01, 7'b0000001);
    wr(1, 0, 8'h22, core_fn(8'h22), '0);
    go();
    wait_done("t6_timeout");
`ifdef VECCHK_MASK_EN
    chk("t6_err", 0, err_a, 0);
    chk("t6_pass", 0, pass_a, 1);
`else
    chk("t6_err", 0, err_a, 1);
    chk("t6_fch", 0, fch_a, 7'b0000001);
`endif
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
